// File: rtl/data_resp_pkg.sv
// Shared definitions for the data SRAM responder: confreg window, offsets and FSM states.
package data_resp_pkg;

    localparam int unsigned DW          = 32;
    localparam logic [15:0] CONF_HI_DEF = 16'hbfaf;

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_NUM    = 16'h0004;
    localparam logic [15:0] OFF_TIMER  = 16'h0008;
    localparam logic [15:0] OFF_SWITCH = 16'h000C;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

endpackage

// File: rtl/data_resp_ram.sv
// Word-wide data RAM: asynchronous read, single synchronous write port.
module data_resp_ram #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_sram_resp.sv
// CPU data SRAM responder: RAM clear FSM, address decode, confreg (LED/NUM/TIMER/SWITCH).
// Optional TIMER register enabled by defining DATA_RESP_TIMER_EN.
module data_sram_resp
    import data_resp_pkg::*;
#(
    parameter int unsigned RAM_AW       = 12,
    parameter logic [15:0] CONF_HI      = CONF_HI_DEF,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          data_sram_we,
    input  logic [31:0]   data_sram_addr,
    input  logic [31:0]   data_sram_wdata,
    output logic [31:0]   data_sram_rdata,
    input  logic [7:0]    switch_in,
    output logic [15:0]   led_out,
    output logic [31:0]   num_out,
    output logic          init_done
);

    localparam state_t RST_STATE = CLEAR_ON_RST ? S_CLEAR : S_READY;

    state_t            state_q, state_d;
    logic [RAM_AW-1:0] idx_q, idx_d;
    logic              init_done_q;
    logic [15:0]       led_q;
    logic [31:0]       num_q;

    logic              clr_we_c, ready_c, cpu_wr_c, is_conf_c;
    logic [15:0]       off_c;
    logic [RAM_AW-1:0] cpu_idx_c, ram_waddr_c;
    logic              ram_we_c;
    logic [DW-1:0]     ram_wdata_c, ram_rdata_c, timer_val_c;
    logic              unused_c;

    assign is_conf_c = (data_sram_addr[31:16] == CONF_HI);
    assign off_c     = {data_sram_addr[15:2], 2'b00};
    assign cpu_idx_c = data_sram_addr[RAM_AW+1:2];
    assign cpu_wr_c  = data_sram_we & ready_c;
    assign unused_c  = ^data_sram_addr[1:0];

    // FSM state register and clear index
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RST_STATE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_CLEAR: begin
                idx_d = idx_q + RAM_AW'(1);
                if (idx_q == '1) begin
                    state_d = S_READY;
                end
            end
            S_READY: state_d = S_READY;
            default: state_d = RST_STATE;
        endcase
    end

    always_comb begin
        clr_we_c = 1'b0;
        ready_c  = 1'b0;
        case (state_q)
            S_CLEAR: clr_we_c = 1'b1;
            S_READY: ready_c  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            init_done_q <= (RST_STATE == S_READY);
        end else begin
            init_done_q <= (state_d == S_READY);
        end
    end

    // RAM write port: clear sweep has priority, CPU writes only once ready
    assign ram_we_c    = clr_we_c | (cpu_wr_c & ~is_conf_c);
    assign ram_waddr_c = clr_we_c ? idx_q : cpu_idx_c;
    assign ram_wdata_c = clr_we_c ? '0 : data_sram_wdata;

    data_resp_ram #(
        .AW (RAM_AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_c),
        .waddr_i (ram_waddr_c),
        .wdata_i (ram_wdata_c),
        .raddr_i (cpu_idx_c),
        .rdata_o (ram_rdata_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q <= '0;
            num_q <= '0;
        end else if (cpu_wr_c && is_conf_c) begin
            if (off_c == OFF_LED) led_q <= data_sram_wdata[15:0];
            if (off_c == OFF_NUM) num_q <= data_sram_wdata;
        end
    end

`ifdef DATA_RESP_TIMER_EN
    logic [31:0] timer_q;

    // Free-running counter; a CPU write overrides that cycle's increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q <= '0;
        end else if (cpu_wr_c && is_conf_c && (off_c == OFF_TIMER)) begin
            timer_q <= data_sram_wdata;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign timer_val_c = timer_q;
`else
    assign timer_val_c = '0;
`endif

    always_comb begin
        data_sram_rdata = '0;
        if (ready_c) begin
            if (is_conf_c) begin
                case (off_c)
                    OFF_LED:    data_sram_rdata = {16'h0, led_q};
                    OFF_NUM:    data_sram_rdata = num_q;
                    OFF_TIMER:  data_sram_rdata = timer_val_c;
                    OFF_SWITCH: data_sram_rdata = {24'h0, switch_in};
                    default:    data_sram_rdata = '0;
                endcase
            end else begin
                data_sram_rdata = ram_rdata_c;
            end
        end
    end

    assign led_out   = led_q;
    assign num_out   = num_q;
    assign init_done = init_done_q;

endmodule
